cache_control_nway: RTL and testbench

CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

---
 rtl/cache_control_nway_if.sv | 41 ++++
 rtl/cache_control_nway.sv | 158 +++++++++++++++
 tb/tb_cache_control_nway.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_nway_if.sv
// CPU-side and memory-side signal bundle for the N-way cache controller.
// master drives requests and tag-array status; slave is the controller.
interface cache_control_nway_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);

    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic [IDX_W-1:0] set_idx;
    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  valid_vec;
    logic [WAYS-1:0]  dirty_vec;
    logic [WAY_W-1:0] way_sel;
    logic             tag_sel;
    logic             source_sel;
    logic             load_cache;
    logic             load_valid;
    logic             load_dirty;
    logic             dirty_in;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;

    modport master (
        output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec,
        output pmem_resp,
        input  mem_resp, way_sel, tag_sel, source_sel, load_cache,
        input  load_valid, load_dirty, dirty_in, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec,
        input  pmem_resp,
        output mem_resp, way_sel, tag_sel, source_sel, load_cache,
        output load_valid, load_dirty, dirty_in, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller with tree-PLRU replacement.
// Handles hit, clean-miss fill and dirty-miss writeback-then-fill.
module cache_control_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input logic                 clk,
    input logic                 rst,
    cache_control_nway_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int NODES = WAYS - 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [WAY_W-1:0]             r_victim;
    logic [SETS-1:0][NODES-1:0]   r_plru;

    logic                         w_req;
    logic                         w_hit;
    logic [WAYS-1:0]              w_hv;
    logic [WAYS-1:0]              w_vd;
    logic [WAYS-1:0]              w_vd_sh;
    logic [WAY_W-1:0]             w_hit_way;
    logic [WAY_W-1:0]             w_inv_way;
    logic [WAY_W-1:0]             w_plru_way;
    logic [WAY_W-1:0]             w_victim;
    logic                         w_vdirty;
    logic                         w_latch;
    logic                         w_upd;
    logic [WAY_W-1:0]             w_upd_way;
    logic [NODES-1:0]             w_cur;

    function automatic logic [WAY_W-1:0] lowest(logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        logic [WAYS-1:0]  t;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            t = v >> i;
            if (t[0]) r = WAY_W'(i);
        end
        return r;
    endfunction

    // Walk root to leaf, flipping each node on the path away from way w.
    function automatic logic [NODES-1:0] plru_upd(logic [NODES-1:0] cur,
                                                  logic [WAY_W-1:0] w);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] t;
        int               n;
        r = cur;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            t = w >> (WAY_W - 1 - l);
            r = (r & ~(NODES'(1) << n)) | (NODES'(!t[0]) << n);
            n = 2 * n + 1 + int'(t[0]);
        end
        return r;
    endfunction

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_hv      = bus.hit_vec & bus.valid_vec;
    assign w_hit     = w_req & (|w_hv);
    assign w_hit_way = lowest(w_hv);
    assign w_inv_way = lowest(~bus.valid_vec);
    assign w_cur     = r_plru[bus.set_idx];
    assign w_victim  = (&bus.valid_vec) ? w_plru_way : w_inv_way;
    assign w_vd      = bus.valid_vec & bus.dirty_vec;
    assign w_vd_sh   = w_vd >> w_victim;
    assign w_vdirty  = w_vd_sh[0];

    always_comb begin
        logic [NODES-1:0] t;
        int               n;
        w_plru_way = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            t = w_cur >> n;
            w_plru_way[WAY_W-1-l] = t[0];
            n = 2 * n + 1 + int'(t[0]);
        end
    end

    always_comb begin
        w_next         = r_state;
        w_latch        = 1'b0;
        w_upd          = 1'b0;
        w_upd_way      = r_victim;
        bus.mem_resp   = 1'b0;
        bus.way_sel    = r_victim;
        bus.tag_sel    = 1'b1;
        bus.source_sel = 1'b0;
        bus.load_cache = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_dirty = 1'b0;
        bus.dirty_in   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        // Outputs are forced quiet while reset is held.
        if (rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        bus.mem_resp   = 1'b1;
                        bus.way_sel    = w_hit_way;
                        bus.load_cache = bus.mem_write;
                        bus.load_dirty = bus.mem_write;
                        bus.dirty_in   = bus.mem_write;
                        w_upd          = 1'b1;
                        w_upd_way      = w_hit_way;
                    end else if (w_req) begin
                        w_latch = 1'b1;
                        w_next  = w_vdirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write = 1'b1;
                    bus.tag_sel    = 1'b0;
                    if (bus.pmem_resp) w_next = FILL;
                end
                FILL: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.load_cache = 1'b1;
                        bus.source_sel = 1'b1;
                        bus.load_valid = 1'b1;
                        bus.load_dirty = 1'b1;
                        w_next         = RESPOND;
                    end
                end
                RESPOND: begin
                    bus.mem_resp   = 1'b1;
                    bus.load_cache = bus.mem_write;
                    bus.load_dirty = bus.mem_write;
                    bus.dirty_in   = bus.mem_write;
                    w_upd          = 1'b1;
                    w_next         = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_victim <= '0;
            r_plru   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_victim <= w_victim;
            if (w_upd) r_plru[bus.set_idx] <= plru_upd(w_cur, w_upd_way);
        end
    end
endmodule

// File: tb/tb_cache_control_nway.sv
// Randomised and directed checks of cache_control_nway against a
// recency-based replacement model.
module tb_cache_control_nway;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   ts [SETS][WAYS];
    int   tnow;

    cache_control_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

    cache_control_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int low_set(logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return 0;
    endfunction

    // At each split, head away from the half holding the most recent access.
    function automatic int model_victim(int s);
        int lo, hi, mid, ml, mu;
        lo = 0;
        hi = WAYS;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            ml = 0;
            mu = 0;
            for (int i = lo; i < mid; i++) if (ts[s][i] > ml) ml = ts[s][i];
            for (int i = mid; i < hi; i++) if (ts[s][i] > mu) mu = ts[s][i];
            if (ml > mu) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) ts[s][w] = 0;
        tnow = 0;
    endtask

    function automatic logic [5:0] quiet();
        return {bus.mem_resp, bus.load_cache, bus.load_valid,
                bus.load_dirty, bus.pmem_read, bus.pmem_write};
    endfunction

    task automatic txn(bit wr, int s, logic [WAYS-1:0] hv,
                       logic [WAYS-1:0] vv, logic [WAYS-1:0] dv, int lat);
        logic [WAYS-1:0] hve;
        int              v;
        bit              dirty;
        bus.mem_read  = !wr;
        bus.mem_write = wr;
        bus.set_idx   = 3'(s);
        bus.hit_vec   = hv;
        bus.valid_vec = vv;
        bus.dirty_vec = dv;
        bus.pmem_resp = 1'b0;
        #1;
        hve = hv & vv;
        if (hve != 0) begin
            v = low_set(hve);
            chk("hit_resp", 32'(bus.mem_resp), 1);
            chk("hit_way", 32'(bus.way_sel), 32'(v));
            chk("hit_ld", 32'({bus.load_cache, bus.load_dirty, bus.dirty_in}),
                wr ? 32'd7 : 32'd0);
            chk("hit_srcv", 32'({bus.source_sel, bus.load_valid}), 0);
            chk("hit_pmem", 32'({bus.pmem_read, bus.pmem_write}), 0);
            step();
            tnow++;
            ts[s][v] = tnow;
        end else begin
            v = (&vv) ? model_victim(s) : low_set(~vv);
            dirty = vv[v] & dv[v];
            chk("miss_noresp", 32'(bus.mem_resp), 0);
            step();
            bus.hit_vec   = 4'($urandom);
            bus.valid_vec = 4'($urandom);
            bus.dirty_vec = 4'($urandom);
            if (dirty) begin
                for (int c = 0; c < lat; c++) begin
                    bus.pmem_resp = (c == lat - 1);
                    #1;
                    chk("wb_pmem", 32'({bus.pmem_read, bus.pmem_write}), 1);
                    chk("wb_tag", 32'(bus.tag_sel), 0);
                    chk("wb_way", 32'(bus.way_sel), 32'(v));
                    chk("wb_noresp", 32'(bus.mem_resp), 0);
                    step();
                end
            end
            for (int c = 0; c < lat; c++) begin
                bus.pmem_resp = (c == lat - 1);
                #1;
                chk("fill_pmem", 32'({bus.pmem_read, bus.pmem_write}), 2);
                chk("fill_tag", 32'(bus.tag_sel), 1);
                chk("fill_way", 32'(bus.way_sel), 32'(v));
                chk("fill_noresp", 32'(bus.mem_resp), 0);
                if (c == lat - 1)
                    chk("fill_ld", 32'({bus.load_cache, bus.load_valid,
                        bus.load_dirty, bus.dirty_in, bus.source_sel}), 32'h1d);
                else
                    chk("fill_wait", 32'(bus.load_cache), 0);
                step();
            end
            bus.pmem_resp = 1'b0;
            #1;
            chk("rsp_resp", 32'(bus.mem_resp), 1);
            chk("rsp_way", 32'(bus.way_sel), 32'(v));
            chk("rsp_ld", 32'({bus.load_cache, bus.load_dirty, bus.dirty_in}),
                wr ? 32'd7 : 32'd0);
            chk("rsp_pmem", 32'({bus.pmem_read, bus.pmem_write, bus.load_valid}), 0);
            step();
            tnow++;
            ts[s][v] = tnow;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'($urandom);
        #1;
        chk("idle_quiet", 32'(quiet()), 0);
        step();
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst           = 1'b0;
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        bus.set_idx   = '0;
        bus.hit_vec   = 4'b0001;
        bus.valid_vec = 4'b1111;
        bus.dirty_vec = '0;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_quiet", 32'(quiet()), 0);
        bus.mem_read = 1'b0;
        rst = 1'b1;
        step();

        txn(0, 3, 4'b0000, 4'b1111, 4'b0000, 3);
        txn(0, 3, 4'b0000, 4'b1111, 4'b0000, 2);
        txn(0, 3, 4'b0100, 4'b1111, 4'b0000, 1);
        txn(0, 3, 4'b0000, 4'b1111, 4'b0000, 1);
        txn(1, 2, 4'b1000, 4'b1111, 4'b0000, 1);
        txn(0, 4, 4'b0000, 4'b1111, 4'b1111, 3);
        txn(1, 5, 4'b0000, 4'b1111, 4'b1111, 1);
        txn(0, 6, 4'b0000, 4'b1011, 4'b1111, 2);
        txn(0, 6, 4'b0110, 4'b1111, 4'b0000, 1);

        // Abort a fill with reset, then confirm a clean restart.
        bus.mem_read  = 1'b1;
        bus.set_idx   = 3'd5;
        bus.hit_vec   = '0;
        bus.valid_vec = 4'b1111;
        bus.dirty_vec = '0;
        step();
        #1;
        chk("abort_fill", 32'(bus.pmem_read), 1);
        #1;
        rst = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        chk("abort_quiet", 32'(quiet()), 0);
        @(posedge clk);
        #1;
        chk("abort_hold", 32'(quiet()), 0);
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.pmem_resp = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        txn(0, 3, 4'b0000, 4'b1111, 4'b0000, 2);
        txn(0, 5, 4'b0000, 4'b1111, 4'b0000, 1);

        for (int k = 0; k < 200; k++) begin
            logic [WAYS-1:0] hv, vv, dv;
            vv = ($urandom % 2) ? 4'b1111 : 4'($urandom);
            hv = ($urandom % 2) ? 4'b0000 : 4'($urandom);
            dv = 4'($urandom);
            txn(1'($urandom), int'($urandom % SETS), hv, vv, dv,
                int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
